uart_rx_oversampled: RTL
========================

Name: uart_rx_oversampled

Overview:
- UART receiver for the RS232 link; consumes the single-clk-cycle `tick` strobe produced by the team's baud rate generator, programmed for 16x the bit rate.
- Synchronises the asynchronous `rxd` line and validates the start bit at mid-bit.
- Samples data bits LSB-first at bit centres, with optional parity check and stop-bit check.
- Presents each received byte with a one-cycle valid strobe and error flags.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- OVERSAMPLE, 16, tick strobes per bit period (even, >=4).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- tick  input  1  oversample strobe, high for one clk cycle, OVERSAMPLE per bit time
- rxd  input  1  serial line, idle high, asynchronous to clk
- parity_en  input  1  1 = frame carries a parity bit after the data bits
- parity_odd  input  1  1 = odd parity, 0 = even parity (used only when parity_en=1)
- data_out  output  DATA_BITS  last received data word
- data_valid  output  1  one-clk pulse when a frame completes
- parity_err  output  1  parity mismatch on the last frame
- frame_err  output  1  stop bit sampled low on the last frame
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset is asynchronous, active-low; clock clk. While rst=0:
  - state=IDLE; sync flops=1.
  - tick counter, bit index and shift register = 0.
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
  - Reset asserted mid-frame abandons the frame; no data_valid is produced.
- rxd passes through 2 flops (rxd_s); all decisions use rxd_s only.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - rxd_s=0 -> START, tick counter cleared. Detection does not wait for tick.
  - Counting starts with the next tick.
- START:
  - Each tick increments the counter.
  - At the tick where counter reaches OVERSAMPLE/2-1, sample rxd_s.
    - rxd_s=1 -> false start, return to IDLE with no outputs changed.
    - rxd_s=0 -> counter=0, bit index=0, go to DATA.
  - parity_en and parity_odd are latched at start confirmation; changes mid-frame have no effect.
- DATA:
  - At the tick where counter=OVERSAMPLE-1, sample rxd_s into the shift register LSB-first, counter=0, bit index+1.
  - After DATA_BITS samples: go to PARITY if the latched parity_en=1, else STOP.
- PARITY:
  - Same sampling point (counter=OVERSAMPLE-1).
  - Expected bit = XOR of data bits, XOR 1 if odd parity.
  - Mismatch is recorded internally. Go to STOP.
- STOP:
  - Sample at counter=OVERSAMPLE-1.
  - On the next clk edge:
    - data_out <= shift register.
    - data_valid=1 for exactly one cycle.
    - parity_err <= recorded mismatch (0 if parity disabled).
    - frame_err <= (stop sample==0).
  - Stop sample 1 -> IDLE. Stop sample 0 -> BREAK.
- BREAK: wait for rxd_s=1, then IDLE. A line held low never re-triggers a start. busy=1 in BREAK.
- data_out, parity_err and frame_err hold their values until the next data_valid. data_valid is never asserted outside STOP completion.
- tick in the same cycle as the IDLE start detection is ignored.
- Counter width is clog2(OVERSAMPLE); it never wraps beyond OVERSAMPLE-1.
- Back-to-back frames: a start edge immediately after the stop-bit sample is accepted, because IDLE is re-entered before the line's next falling edge.

Test Plan:
- Bench setup: tick every 4 clks, OVERSAMPLE=16, so 64 clks/bit.
- Clean byte 0xA5, parity_en=0, one stop bit -> exactly one data_valid pulse, data_out=0xA5, parity_err=0, frame_err=0, busy low afterward.
- parity_en=1, parity_odd=0:
  - 0x03 with parity bit 0 -> data_out=0x03, parity_err=0.
  - Repeat with parity bit 1 -> parity_err=1, data_out=0x03.
  - Then parity_odd=1, 0x01 with parity bit 0 -> parity_err=0.
- 0x3C with stop bit driven 0 and line then held low for 5 bit times -> data_valid with data_out=0x3C, frame_err=1.
  - No further data_valid while low; busy stays 1.
  - After the line returns high, the next frame 0x55 -> data_valid, frame_err=0.
- Glitch: rxd low for 3 ticks then high -> no data_valid, busy returns to 0 after the mid-start sample; data_out is unchanged from its previous value.
- Reset: drop rst during bit 4 of frame 0x96 -> all outputs 0 immediately. Release and send 0x69 -> data_out=0x69, no spurious earlier pulse.
- Back-to-back 0x00, 0xFF, 0x81 with zero idle between frames -> three data_valid pulses in order with the correct values and no errors.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// UART receiver fed by a 1-cycle oversample strobe (OVERSAMPLE ticks per bit).
// It confirms the start bit at mid-bit, then samples data, optional parity and stop at bit centres.
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rxd,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [2:0]           state_dbg
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t               state;
    logic                 rxd_meta;
    logic                 rxd_s;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_en_l;
    logic                 par_odd_l;
    logic                 par_mis;

    assign state_dbg = state;

    // Two-flop synchroniser; reset to the idle level so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // data_valid is a single-cycle strobe with no ready: the consumer must take
    // data_out/parity_err/frame_err in that cycle; they hold until the next strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_en_l   <= 1'b0;
            par_odd_l  <= 1'b0;
            par_mis    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // A tick coinciding with detection is deliberately not counted.
                    if (!rxd_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (cnt == HALF_LAST) begin
                            if (rxd_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state     <= DATA;
                                cnt       <= '0;
                                bit_idx   <= '0;
                                par_en_l  <= parity_en;
                                par_odd_l <= parity_odd;
                                par_mis   <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (cnt == FULL_LAST) begin
                            cnt     <= '0;
                            shift   <= {rxd_s, shift[DATA_BITS-1:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == BIT_LAST) begin
                                state <= par_en_l ? PARITY : STOP;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        if (cnt == FULL_LAST) begin
                            cnt     <= '0;
                            par_mis <= rxd_s ^ (^shift) ^ par_odd_l;
                            state   <= STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (cnt == FULL_LAST) begin
                            cnt        <= '0;
                            data_out   <= shift;
                            data_valid <= 1'b1;
                            parity_err <= par_en_l & par_mis;
                            frame_err  <= ~rxd_s;
                            // A low stop bit means the line may stay low; wait it out in BREAK.
                            state      <= rxd_s ? IDLE : BREAK;
                            busy       <= ~rxd_s;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (rxd_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
